// File: rtl/layer_serializer.sv
// layer_serializer: captures a full NN-word layer output and replays it serially.
// SER_BACKPRESSURE_EN: when defined, words are held until i_ready accepts them.
module layer_serializer #(
  parameter int NN  = 30,
  parameter int DW  = 16,
  parameter int GAP = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NN*DW-1:0] i_data,
  input  logic [NN-1:0]    i_valid,
  input  logic             i_ready,
  input  logic             ovr_clr,
  output logic [DW-1:0]    o_data,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [IW-1:0] LAST  = IW'(NN - 1);
  localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAPW
  } state_t;

  state_t               st;
  state_t               st_nxt;
  logic [NN-1:0][DW-1:0] hold;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_nxt;
  logic [GW-1:0]        gcnt;
  logic [GW-1:0]        gcnt_nxt;
  logic [DW-1:0]        data_nxt;
  logic                 full;
  logic                 cap;
  logic                 acc;

  assign full   = &i_valid;
  assign o_busy = (st != IDLE);

`ifdef SER_BACKPRESSURE_EN
  assign acc = o_valid & i_ready;
`else
  logic unused_ready;
  assign unused_ready = i_ready;
  assign acc = o_valid;
`endif

  // next-state, index, gap count and next output word
  always_comb begin
    st_nxt   = st;
    idx_nxt  = idx;
    gcnt_nxt = gcnt;
    cap      = 1'b0;
    unique case (st)
      IDLE: begin
        if (full) begin
          cap     = 1'b1;
          idx_nxt = '0;
          st_nxt  = SEND;
        end
      end
      SEND: begin
        if (acc) begin
          if (idx == LAST) begin
            st_nxt = IDLE;
          end else begin
            idx_nxt  = idx + IW'(1);
            gcnt_nxt = '0;
            st_nxt   = (GAP > 0) ? GAPW : SEND;
          end
        end
      end
      GAPW: begin
        if (gcnt == GLAST) begin
          gcnt_nxt = '0;
          st_nxt   = SEND;
        end else begin
          gcnt_nxt = gcnt + GW'(1);
        end
      end
      default: st_nxt = IDLE;
    endcase
    data_nxt = o_data;
    if (cap) begin
      data_nxt = i_data[DW-1:0];
    end else if (st_nxt == SEND) begin
      data_nxt = hold[idx_nxt];
    end
  end

  // control state and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= IDLE;
      idx  <= '0;
      gcnt <= '0;
    end else begin
      st   <= st_nxt;
      idx  <= idx_nxt;
      gcnt <= gcnt_nxt;
    end
  end

  // frame holding register, loaded only when a frame is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
    end else if (cap) begin
      hold <= i_data;
    end
  end

  // registered serial outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_data  <= data_nxt;
      o_valid <= (st_nxt == SEND);
    end
  end

  // sticky overrun; a dropped frame beats a same-edge clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_overrun <= 1'b0;
    end else if (full && (st != IDLE)) begin
      o_overrun <= 1'b1;
    end else if (ovr_clr) begin
      o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: two instances (GAP=2, GAP=0) checked each cycle
// against a schedule model derived from the frame timing rules.
module tb_layer_serializer;

  localparam int NN = 4;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NN*DW-1:0]     i_data;
  logic [NN-1:0]        i_valid;
  logic                 i_ready;
  logic                 ovr_clr;
  logic [1:0][DW-1:0]   od;
  logic [1:0]           ov;
  logic [1:0]           ob;
  logic [1:0]           oo;

  int                   n_vec = 0;
  int                   n_err = 0;
  int                   ec = 0;
  int                   t0 [2];
  logic [31:0]          fr [2];
  logic                 ovr_m [2];
  logic [7:0]           ed [2];

  always #5 clk = ~clk;

  layer_serializer #(.NN(NN), .DW(DW), .GAP(2)) u_g2 (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .i_ready(i_ready), .ovr_clr(ovr_clr), .o_data(od[0]),
    .o_valid(ov[0]), .o_busy(ob[0]), .o_overrun(oo[0])
  );

  layer_serializer #(.NN(NN), .DW(DW), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .i_ready(i_ready), .ovr_clr(ovr_clr), .o_data(od[1]),
    .o_valid(ov[1]), .o_busy(ob[1]), .o_overrun(oo[1])
  );

  function automatic int gp(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      t0[d]    = -1000;
      fr[d]    = '0;
      ovr_m[d] = 1'b0;
      ed[d]    = '0;
    end
  endtask

  // one clock: update the model with the sampled inputs, then compare
  task automatic step(bit do_chk);
    int  l;
    int  c;
    int  k;
    bit  busy;
    bit  vld;
    bit  full;
    @(posedge clk);
    ec++;
    full = (i_valid == 4'hF);
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        l    = t0[d] + 1 + (NN - 1) * (gp(d) + 1);
        busy = (ec >= t0[d] + 1) && (ec <= l);
        if (full && busy) ovr_m[d] = 1'b1;
        else if (ovr_clr) ovr_m[d] = 1'b0;
        if (full && !busy) begin
          t0[d] = ec;
          fr[d] = i_data;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      c    = ec + 1;
      l    = t0[d] + 1 + (NN - 1) * (gp(d) + 1);
      busy = (c >= t0[d] + 1) && (c <= l);
      vld  = busy && (((c - t0[d] - 1) % (gp(d) + 1)) == 0);
      if (vld) begin
        k     = (c - t0[d] - 1) / (gp(d) + 1);
        ed[d] = fr[d][k*8 +: 8];
      end
      if (do_chk) begin
        chk($sformatf("gap%0d valid @%0d", gp(d), c), 32'(ov[d]), 32'(vld));
        chk($sformatf("gap%0d busy @%0d", gp(d), c), 32'(ob[d]), 32'(busy));
        chk($sformatf("gap%0d data @%0d", gp(d), c), 32'(od[d]), 32'(ed[d]));
        chk($sformatf("gap%0d ovr @%0d", gp(d), c), 32'(oo[d]), 32'(ovr_m[d]));
      end
    end
  endtask

  task automatic chk_zero(string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s valid%0d", tag, d), 32'(ov[d]), 32'd0);
      chk($sformatf("%s busy%0d", tag, d), 32'(ob[d]), 32'd0);
    end
  endtask

  initial begin
    model_reset();
    rst     = 1'b0;
    i_data  = $urandom;
    i_valid = 4'hF;
    i_ready = 1'b1;
    ovr_clr = 1'b0;
    #2;
    chk_zero("reset");
    chk("reset data", 32'(od[0]), 32'd0);
    chk("reset ovr", 32'(oo[0]), 32'd0);
    repeat (3) begin
      i_data = $urandom;
      step(1);
    end
    i_valid = 4'h0;
    rst     = 1'b1;
    repeat (3) step(1);

    // basic frame on the GAP=2 instance
    i_data  = 32'h44332211;
    i_valid = 4'hF;
    step(1);
    i_valid = 4'h0;
    chk("basic w0 valid", 32'(ov[0]), 32'd1);
    chk("basic w0 data", 32'(od[0]), 32'h11);
    repeat (3) step(1);
    chk("basic w1 data", 32'(od[0]), 32'h22);
    repeat (7) step(1);
    chk("basic idle", 32'(ob[0]), 32'd0);
    repeat (2) step(1);

    // back-to-back on GAP=0, second frame at the first idle edge
    i_valid = 4'hF;
    step(1);
    i_valid = 4'h0;
    repeat (4) step(1);
    i_data  = 32'hDDCCBBAA;
    i_valid = 4'hF;
    step(1);
    i_valid = 4'h0;
    chk("b2b 2nd w0 valid", 32'(ov[1]), 32'd1);
    chk("b2b 2nd w0 data", 32'(od[1]), 32'hAA);
    repeat (12) step(1);
    chk("b2b overrun g2", 32'(oo[0]), 32'd1);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    chk("clr overrun", 32'(oo[0]), 32'd0);

    // overrun during a frame, then a late clear
    i_data  = 32'h44332211;
    i_valid = 4'hF;
    step(1);
    i_valid = 4'h0;
    repeat (2) step(1);
    i_data  = 32'h8899AABB;
    i_valid = 4'hF;
    step(1);
    i_valid = 4'h0;
    chk("ovr set", 32'(oo[0]), 32'd1);
    repeat (16) step(1);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    chk("ovr cleared", 32'(oo[0]), 32'd0);

    // partial valid patterns never capture
    i_valid = 4'hB;
    repeat (10) step(1);
    i_valid = 4'h0;
    chk("partial busy", 32'(ob[0]), 32'd0);
    chk("partial ovr", 32'(oo[0]), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      i_data  = $urandom;
      i_valid = ($urandom_range(7, 0) < 2) ? 4'hF : 4'($urandom);
      ovr_clr = ($urandom_range(15, 0) == 0);
`ifndef SER_BACKPRESSURE_EN
      i_ready = 1'($urandom);
`endif
      step(1);
    end
    i_valid = 4'h0;
    ovr_clr = 1'b0;
    i_ready = 1'b1;
    repeat (12) step(1);

    // reset in the middle of a frame
    i_data  = 32'h44332211;
    i_valid = 4'hF;
    step(1);
    i_valid = 4'h0;
    repeat (4) step(1);
    rst = 1'b0;
    #1;
    chk_zero("midreset");
    model_reset();
    step(1);
    rst = 1'b1;
    repeat (12) step(1);

`ifdef SER_BACKPRESSURE_EN
    // word 0 held while ready is low
    i_data  = 32'h44332211;
    i_valid = 4'hF;
    i_ready = 1'b0;
    step(0);
    i_valid = 4'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp hold valid", 32'(ov[0]), 32'd1);
      chk("bp hold data", 32'(od[0]), 32'h11);
      step(0);
    end
    i_ready = 1'b1;
    chk("bp pre-accept", 32'(od[0]), 32'h11);
    step(0);
    chk("bp gap0", 32'(ov[0]), 32'd0);
    step(0);
    chk("bp gap1", 32'(ov[0]), 32'd0);
    step(0);
    chk("bp w1 valid", 32'(ov[0]), 32'd1);
    chk("bp w1 data", 32'(od[0]), 32'h22);
    rst = 1'b0;
    #1;
    model_reset();
    rst = 1'b1;
    repeat (3) step(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/layer_serializer.md
Name: layer_serializer

Overview:
- Parametrised parallel-to-serial bridge between neuron layers.
- Captures the full output vector of one layer (NN words of DW bits) once every neuron's valid is high.
- Replays the words one per slot, lowest index first, into the broadcast input of the next layer, with a programmable idle gap between words.
- Replaces hand-written per-layer serializer FSMs. Adds configurable width, depth and gap, overrun detection, a busy flag and optional downstream backpressure.

Parameters:
- NN, 30, number of words (neurons) captured per frame; must be at least 1.
- DW, 16, width of each word in bits.
- GAP, 6, idle cycles inserted after each accepted word before the next word is presented; 0 means back-to-back words.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- i_data  input  NN*DW  layer outputs; word k is i_data[k*DW +: DW].
- i_valid  input  NN  per-neuron valid flags.
- i_ready  input  1  downstream ready; used only when SER_BACKPRESSURE_EN is defined, ignored otherwise.
- ovr_clr  input  1  synchronous clear of o_overrun.
- o_data  output  DW  current serial word.
- o_valid  output  1  o_data is valid.
- o_busy  output  1  a frame is held (state is not IDLE).
- o_overrun  output  1  sticky flag: a complete input frame arrived while busy and was dropped.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, word index=0, gap counter=0, o_data=0, o_valid=0, o_busy=0, o_overrun=0. Holding register is cleared to 0.
- Frame-complete condition: i_valid is all-ones. Any partial valid pattern is ignored entirely.
- States:
  - IDLE: on an edge with the frame-complete condition, latch i_data into the holding register, set index=0 and go to SEND. Otherwise stay in IDLE.
  - SEND: o_data = holding word[index]; o_valid=1.
    - Word is accepted at the edge where o_valid=1, and also i_ready=1 when the macro is defined.
    - On acceptance of the last word (index==NN-1): go to IDLE directly (no trailing gap) and drop o_valid.
    - On acceptance of any other word: index+1; go to GAPW if GAP>0, else stay in SEND presenting the next word on the next cycle.
  - GAPW: o_valid=0; count GAP cycles, then go to SEND.
- Latency: frame captured at edge t; word 0 is valid during cycle t+1.
- Timing without backpressure:
  - Word k is valid for exactly one cycle, starting at cycle t+1+k*(GAP+1).
  - The frame occupies NN*(GAP+1)-GAP cycles.
- o_data and o_valid are registered outputs. o_data holds its last value while o_valid=0.
- o_busy is high in SEND and GAPW.
- Return to IDLE: the cycle after the last word is accepted, the block is in IDLE and can capture a new frame on that same edge.
- Overrun:
  - A frame-complete condition at an edge where state is not IDLE sets o_overrun=1. The new frame is discarded; the current frame continues unaffected.
  - ovr_clr=1 clears o_overrun. If clear and a set occur at the same edge, set wins.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost and nothing resumes after reset is released.
- Counters: index width is clog2(NN) (minimum 1); gap counter width is clog2(GAP+1) (minimum 1).

Optional Feature:
- Macro SER_BACKPRESSURE_EN.
- Defined: in SEND, o_valid and o_data are held stable until an edge with i_ready=1. The gap starts only after acceptance. i_ready=0 during GAPW or IDLE has no effect.
- Not defined: i_ready is ignored. Each word is valid for exactly one cycle, giving a fixed-rate stream.

Test Plan:
- Reset check: assert rst=0 with random inputs -> o_valid=0, o_busy=0, o_overrun=0, o_data=0. Release reset -> no o_valid until a full frame arrives.
- Basic frame, NN=4, DW=8, GAP=2, i_data=0x44332211, i_valid=4'hF for 1 cycle at edge t -> o_valid pulses at t+1, t+4, t+7, t+10 with o_data=0x11, 0x22, 0x33, 0x44. o_busy=0 from t+11.
- Back-to-back, NN=4, GAP=0 -> o_valid high for cycles t+1..t+4 with 0x11..0x44. A second full frame presented at the edge t+5 (first IDLE cycle) is captured, and its word 0 appears at t+6.
- Partial valid, i_valid=4'hB for 10 cycles -> no capture, o_busy stays 0, o_overrun stays 0.
- Overrun: full frame presented again at t+3 during the basic frame -> o_overrun=1 from t+4; the original 4 words are still output unchanged. ovr_clr pulsed at t+20 -> o_overrun=0.
- Reset mid-frame, plus backpressure with SER_BACKPRESSURE_EN defined:
  - rst=0 at t+5 -> o_valid=0 and o_busy=0 immediately.
  - With the macro, hold i_ready=0 for 5 cycles on word 0 -> o_data=0x11 and o_valid held stable. Word 1 valid 3 cycles after the i_ready=1 edge (GAP=2).
